// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: converts BCD MM:SS digits to active-low seven-segment
// patterns for the scan driver, blinks the selected field in adjust mode and
// overlays a one-shot message for MSG_BLINKS blink periods.
// Optional build macro: SEG_COLON_DP_EN (lights digit 2 dp as the MM.SS separator).
module seg_display_ctrl #(
  parameter int MSG_BLINKS = 4
) (
  input  logic       MegaClk,
  input  logic       reset,
  input  logic       clk_blink,
  input  logic       adj,
  input  logic       sel,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       msg_valid,
  input  logic [7:0] msg_bits [0:3],
  output logic       msg_ready,
  output logic [7:0] displayBits [0:3]
);

  typedef enum logic {ST_TIME, ST_SHOW} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       load_buf;
  logic       blink_prev;
  logic       blink_phase;
  logic       blink_rise;
  logic [7:0] msg_buf   [0:3];
  logic [7:0] disp_next [0:3];

  // Active-low {dp,g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hBF;
    endcase
  endfunction

  assign blink_rise = clk_blink && !blink_prev;

  // Blink edge detector; prev resets high so a high clk_blink at release is not an edge.
  always_ff @(posedge MegaClk) begin
    if (reset) begin
      blink_prev  <= 1'b1;
      blink_phase <= 1'b0;
    end else begin
      blink_prev <= clk_blink;
      if (blink_rise) blink_phase <= ~blink_phase;
    end
  end

  // FSM state register, message countdown and registered ready flag.
  always_ff @(posedge MegaClk) begin
    if (reset) begin
      state     <= ST_TIME;
      cnt       <= 4'd0;
      msg_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      msg_ready <= (state_next == ST_TIME);
    end
  end

  // Next-state logic: accept a message in TIME, count blink edges in SHOW.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_buf   = 1'b0;
    case (state)
      ST_TIME: begin
        if (msg_valid && msg_ready) begin
          state_next = ST_SHOW;
          cnt_next   = 4'(MSG_BLINKS);
          load_buf   = 1'b1;
        end
      end
      ST_SHOW: begin
        if (blink_rise) begin
          cnt_next = cnt - 4'd1;
          if (cnt == 4'd1) state_next = ST_TIME;
        end
      end
      default: state_next = ST_TIME;
    endcase
  end

  // Message buffer: captured at the handshake, frozen for the whole SHOW interval.
  always_ff @(posedge MegaClk) begin
    if (reset) begin
      msg_buf <= '{default: 8'hFF};
    end else if (load_buf) begin
      msg_buf <= msg_bits;
    end
  end

  // Output select: message verbatim in SHOW, decoded time with blanking in TIME.
  always_comb begin
    disp_next = msg_buf;
    if (state == ST_TIME) begin
      disp_next[0] = seg_decode(sec_ones);
      disp_next[1] = seg_decode(sec_tens);
      disp_next[2] = seg_decode(min_ones);
      disp_next[3] = seg_decode(min_tens);
`ifdef SEG_COLON_DP_EN
      disp_next[2][7] = 1'b0;
`endif
      // Blanking applied last so a blanked digit also loses the separator dp.
      if (adj && blink_phase) begin
        if (sel) begin
          disp_next[0] = 8'hFF;
          disp_next[1] = 8'hFF;
        end else begin
          disp_next[2] = 8'hFF;
          disp_next[3] = 8'hFF;
        end
      end
    end
  end

  // Registered display output.
  always_ff @(posedge MegaClk) begin
    if (reset) begin
      displayBits <= '{default: 8'hFF};
    end else begin
      displayBits <= disp_next;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl: directed steps from the test plan followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_seg_display_ctrl;

  localparam int MSG_BLINKS = 2;

  logic       MegaClk = 1'b0;
  logic       reset;
  logic       clk_blink;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       msg_valid;
  logic [7:0] msg_bits    [0:3];
  logic       msg_ready;
  logic [7:0] displayBits [0:3];

  int checks   = 0;
  int failures = 0;

  seg_display_ctrl #(.MSG_BLINKS(MSG_BLINKS)) dut (
    .MegaClk     (MegaClk),
    .reset       (reset),
    .clk_blink   (clk_blink),
    .adj         (adj),
    .sel         (sel),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .msg_valid   (msg_valid),
    .msg_bits    (msg_bits),
    .msg_ready   (msg_ready),
    .displayBits (displayBits)
  );

  always #5 MegaClk = ~MegaClk;

  // Reference model: integer bookkeeping of blink edges and message lifetime.
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
  logic        m_prev_blink;
  int          m_rises;
  int          m_msg_left;
  logic [31:0] m_buf;
  logic        m_ready;
  logic [31:0] m_disp;

  function automatic logic [31:0] time_view(input logic [3:0] mt, mo, st, so,
                                            input logic a, s, input int rises);
    logic [7:0] d [0:3];
    d[0] = seg_tab[so];
    d[1] = seg_tab[st];
    d[2] = seg_tab[mo];
    d[3] = seg_tab[mt];
`ifdef SEG_COLON_DP_EN
    d[2][7] = 1'b0;
`endif
    if (a && (rises % 2 == 1)) begin
      if (s) begin d[0] = 8'hFF; d[1] = 8'hFF; end
      else   begin d[2] = 8'hFF; d[3] = 8'hFF; end
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic model_step();
    logic rise;
    if (reset) begin
      m_prev_blink = 1'b1;
      m_rises      = 0;
      m_msg_left   = 0;
      m_buf        = 32'hFFFF_FFFF;
      m_ready      = 1'b0;
      m_disp       = 32'hFFFF_FFFF;
    end else begin
      rise   = clk_blink && !m_prev_blink;
      m_disp = (m_msg_left > 0) ? m_buf
             : time_view(min_tens, min_ones, sec_tens, sec_ones, adj, sel, m_rises);
      if (m_msg_left == 0) begin
        if (msg_valid && m_ready) begin
          m_buf      = {msg_bits[3], msg_bits[2], msg_bits[1], msg_bits[0]};
          m_msg_left = MSG_BLINKS;
        end
      end else if (rise) begin
        m_msg_left = m_msg_left - 1;
      end
      m_ready = (m_msg_left == 0);
      if (rise) m_rises = m_rises + 1;
      m_prev_blink = clk_blink;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge, then outputs are compared.
  task automatic tick();
    model_step();
    @(posedge MegaClk);
    #1;
    chk("model_disp", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, m_disp);
    chk("model_ready", {31'd0, msg_ready}, {31'd0, m_ready});
  endtask

  task automatic set_digits(input logic [3:0] mt, mo, st, so);
    min_tens = mt; min_ones = mo; sec_tens = st; sec_ones = so;
  endtask

  initial begin
    reset = 1'b1; clk_blink = 1'b0; adj = 1'b0; sel = 1'b0; msg_valid = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    msg_bits = '{default: 8'h00};
    #1;
    repeat (3) tick();
    chk("rst_disp", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hFFFF_FFFF);
    chk("rst_ready", {31'd0, msg_ready}, 32'd0);

    // Reset release: ready after one cycle, zeros after two.
    reset = 1'b0;
    tick();
    chk("rel_ready", {31'd0, msg_ready}, 32'd1);
    tick();
    chk("rel_zeros", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hC0C0_C0C0);

    // Adjust seconds: seconds pair blinks on each rising edge, minutes hold.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4); adj = 1'b1; sel = 1'b1;
    tick(); tick();
    chk("adj_show", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hF9A4_B099);
    clk_blink = 1'b1; tick(); tick();
    chk("adj_blank", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hF9A4_FFFF);
    clk_blink = 1'b0; tick(); tick();
    chk("adj_hold", {displayBits[1], displayBits[0]}, 32'h0000_FFFF);
    clk_blink = 1'b1; tick(); tick();
    chk("adj_unblank", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hF9A4_B099);
    clk_blink = 1'b0;

    // Non-BCD digit shows a dash.
    min_ones = 4'd12; tick(); tick();
    chk("dash", {24'd0, displayBits[2]}, 32'h0000_00BF);
    min_ones = 4'd2;

    // Message: accepted, shown unblinked, held for two blink edges.
    msg_bits = '{8'h86, 8'hAF, 8'hAF, 8'hA3};
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    msg_bits = '{default: 8'h55};
    chk("msg_ready_drop", {31'd0, msg_ready}, 32'd0);
    tick();
    chk("msg_shown", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hA3AF_AF86);
    msg_valid = 1'b1; msg_bits = '{default: 8'h11};
    clk_blink = 1'b1; tick();
    clk_blink = 1'b0; tick();
    msg_valid = 1'b0;
    tick(); tick();
    chk("msg_still", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hA3AF_AF86);
    chk("msg_busy", {31'd0, msg_ready}, 32'd0);
    clk_blink = 1'b1; tick();
    chk("msg_ret_ready", {31'd0, msg_ready}, 32'd1);
    tick();
    chk("msg_ret_time", {displayBits[3], displayBits[2]}, 32'h0000_F9A4);
    clk_blink = 1'b0; tick();

    // Reset mid-message drops it.
    msg_bits = '{8'h01, 8'h02, 8'h03, 8'h04};
    msg_valid = 1'b1; tick();
    msg_valid = 1'b0; tick(); tick();
    reset = 1'b1; tick();
    chk("show_rst", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hFFFF_FFFF);
    reset = 1'b0; adj = 1'b0; tick(); tick();
    chk("show_rst_ready", {31'd0, msg_ready}, 32'd1);
    chk("show_rst_time", {displayBits[3], displayBits[2], displayBits[1], displayBits[0]}, 32'hF9A4_B099);

    // Separator dp on digit 2.
    min_ones = 4'd5; tick(); tick();
`ifdef SEG_COLON_DP_EN
    chk("dp", {24'd0, displayBits[2]}, 32'h0000_0012);
`else
    chk("dp", {24'd0, displayBits[2]}, 32'h0000_0092);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) clk_blink = ~clk_blink;
      adj       = 1'($urandom_range(0, 1));
      sel       = 1'($urandom_range(0, 1));
      msg_valid = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 4; k++) msg_bits[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Display content controller feeding the seven-segment scan driver. Converts four BCD time digits (MM:SS) into active-low segment patterns and blanks the selected field at the blink rate while in adjust mode. Arbitrates the display between the time view and a one-shot message requester that holds the display for a fixed number of blink periods. Sits between the stopwatch/clock core and the scan driver, driving its `displayBits[0:3]` input.

## Interface
Parameters:
- `MSG_BLINKS`, default 4: number of `clk_blink` rising edges a message stays on screen; legal range 1..15.

Ports:
- `MegaClk` input 1: system clock. All logic runs on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clk_blink` input 1: slow blink clock, treated as a level and sampled on `MegaClk`.
- `adj` input 1: adjust mode; the selected field blinks.
- `sel` input 1: field select. 0 selects minutes (digits 3,2); 1 selects seconds (digits 1,0).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` input 4 each: BCD digits.
- `msg_valid` input 1: message request.
- `msg_bits[0:3]` input 8 each: raw active-low segment patterns for the message, indexed like `displayBits`.
- `msg_ready` output 1: controller accepts a message this cycle.
- `displayBits[0:3]` output 8 each: active-low `{dp,g,f,e,d,c,b,a}`. Index 0 is AN0 (rightmost, `sec_ones`) and index 3 is `min_tens`.

## Operation
- Blink edge detect: `blink_prev` register. `blink_rise = clk_blink && !blink_prev`. `blink_phase` toggles on every `blink_rise`, including while in SHOW.
- Decode: digits 0..9 map to C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Codes 10..15 display a dash, BF.
- FSM states:
  - TIME:
    - `msg_ready=1`.
    - When `msg_valid && msg_ready`, latch `msg_bits` into the internal buffer, load `cnt=MSG_BLINKS`, and go to SHOW.
  - SHOW:
    - `msg_ready=0`. `msg_valid` is ignored.
    - Each `blink_rise` decrements `cnt`. A `blink_rise` with `cnt==1` returns to TIME.
    - A `blink_rise` in the capture cycle is not counted.
- Output select:
  - SHOW: `displayBits` equals the latched buffer. No blanking is applied, and `adj`/`sel` have no effect.
  - TIME: `displayBits` equals the decoded digits.
  - TIME with `adj=1 && blink_phase=1`: the selected pair is forced to FF. The other pair is unaffected.
- Buffer contents are stable for the whole SHOW interval, even if `msg_bits` changes.
- `sel` or `adj` changing mid-blink takes effect on the next output update. `blink_phase` is not reset by these changes.

## Timing
- Reset values:
  - `displayBits[0..3]` = FF; `msg_ready` = 0.
  - State = TIME, `cnt` = 0, `blink_phase` = 0, `blink_prev` = 1. Resetting `blink_prev` to 1 prevents a spurious edge if `clk_blink` is high at release.
  - Message buffer = FF.
- `msg_ready` is registered and reads 1 from the first cycle after `reset` deasserts.
- `displayBits` is registered: the value at cycle k+1 is a function of the state, digits and `blink_phase` at cycle k. Digit-input-to-output latency is 1 cycle.
- Message acceptance:
  - Handshake at cycle N.
  - N+1: state SHOW, `msg_ready=0`.
  - N+2: `displayBits` shows the message.
- Message return:
  - Final `blink_rise` at cycle M.
  - M+1: state TIME, `msg_ready=1`.
  - M+2: time view restored.
  - A new `msg_valid` may be accepted at M+1.
- `reset` asserted mid-SHOW: the message is dropped, and the next cycle shows the reset values.
- `msg_valid` and `blink_rise` in the same TIME cycle: the message is accepted and `blink_phase` still toggles.

## Configuration
- `SEG_COLON_DP_EN`
  - Defined: in TIME, `displayBits[2]` bit 7 is driven 0 (dp lit as the MM.SS separator), except when that digit is blanked by the blink. In SHOW, the message dp bits pass through unchanged.
  - Undefined: bit 7 comes only from the decode table (always 1) in TIME.

## Test plan
- Reset release with all digits 0, `adj=0`: `displayBits` = FF×4 during reset, C0×4 two cycles after release, `msg_ready=1` one cycle after release.
- Digits 1,2,3,4 (min_tens..sec_ones), `adj=1`, `sel=1`, toggle `clk_blink`: `displayBits[3:2]` hold F9/A4. `displayBits[1:0]` alternate B0/99 and FF on each rising edge.
- `min_ones=12`: `displayBits[2]` = BF.
- `MSG_BLINKS=2`:
  - Stimulus: pulse `msg_valid` with `msg_bits` = 86,AF,AF,A3 and `adj=1`.
  - Message appears 2 cycles after the handshake, unblinked. `msg_ready=0` until the 2nd `blink_rise`, then the time view returns 2 cycles after that edge.
  - A second `msg_valid` during SHOW is ignored.
- `reset` during SHOW: FF×4 the next cycle, then the time view with `msg_ready=1`.
- With `SEG_COLON_DP_EN` defined and `min_ones=5`: `displayBits[2]` = 12. Undefined: 92.
